// File: rtl/bconv_host_ctrl_pkg.sv
// rtl/bconv_host_ctrl_pkg.sv - shared types and constants for the bconv host controller
package bconv_host_ctrl_pkg;

    typedef enum logic [2:0] {
        S_LOAD,
        S_KICK,
        S_WAIT_HI,
        S_WAIT_LO,
        S_READ,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]  DIM_10    = 8'd10;
    localparam logic [7:0]  DIM_12    = 8'd12;
    localparam logic [7:0]  DIM_16    = 8'd16;
    localparam logic [15:0] TERM_WORD = 16'h00FF;
    localparam int          WT_ADDR   = 1;

    // A header is legal only for the matrix sizes the accelerator supports.
    function automatic logic dim_ok(input logic [7:0] n);
        return (n == DIM_10) || (n == DIM_12) || (n == DIM_16);
    endfunction

endpackage

// File: rtl/bconv_host_ctrl_if.sv
// rtl/bconv_host_ctrl_if.sv - load word stream and result stream bundle
interface bconv_host_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_last;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_last
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_last
    );
endinterface

// File: rtl/bconv_rd_fifo.sv
// rtl/bconv_rd_fifo.sv - 2-entry readback buffer with credit for 1-cycle-latency SRAM
module bconv_rd_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         issue,
    input  logic [W-1:0] rd_data,
    input  logic         pop,
    output logic         credit,
    output logic         valid,
    output logic [W-1:0] data
);
    logic         inflight;
    logic [1:0]   count;
    logic         wp;
    logic         rp;
    logic [W-1:0] mem [0:1];
    logic         do_pop;

    // A new read may go out only if its data is guaranteed a free slot.
    assign credit = (count + {1'b0, inflight}) < 2'd2;
    assign valid  = (count != 2'd0);
    assign data   = mem[rp];
    assign do_pop = pop && valid;

    // Track the read in flight and the occupancy/pointers of the two slots.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            wp       <= 1'b0;
            rp       <= 1'b0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                wp <= ~wp;
            end
            if (do_pop) begin
                rp <= ~rp;
            end
            count <= count + {1'b0, inflight} - {1'b0, do_pop};
        end
    end

    // Capture SRAM data the cycle after its read was issued.
    always_ff @(posedge clk) begin
        if (inflight) begin
            mem[wp] <= rd_data;
        end
    end

endmodule

// File: rtl/bconv_host_ctrl.sv
// rtl/bconv_host_ctrl.sv - host-side load/kick/readback controller for the bconv accelerator
module bconv_host_ctrl
    import bconv_host_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int START_TO = 16,
    parameter int RUN_TO   = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    bconv_host_ctrl_if.slave     host,
    input  logic                 wt_wr_en,
    input  logic [8:0]           wt_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_W-1:0]    isram_write_address,
    output logic [DATA_W-1:0]    isram_write_data,
    output logic                 isram_write_enable,
    output logic [ADDR_W-1:0]    wmem_write_address,
    output logic [DATA_W-1:0]    wmem_write_data,
    output logic                 wmem_write_enable,
    output logic [ADDR_W-1:0]    osram_read_address,
    input  logic [DATA_W-1:0]    osram_read_data,
    output logic                 dut_run,
    input  logic                 dut_busy
);
    localparam logic [ADDR_W-1:0] ONE       = 1;
    localparam logic [ADDR_W-1:0] TWO       = 2;
    localparam logic [15:0]       START_LIM = 16'(START_TO - 1);
    localparam logic [15:0]       RUN_LIM   = 16'(RUN_TO - 1);

    state_t              state;
    state_t              state_d;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   out_total;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   pop_idx;
    logic [7:0]          rows_left;
    logic                hdr_exp;
    logic                term_pend;
    logic [15:0]         tmr;
    logic                accept;
    logic                term_hit;
    logic                bad_word;
    logic                write_ok;
    logic                wt_ok;
    logic                issue;
    logic                pop;
    logic                fifo_credit;
    logic                fifo_valid;
    logic [DATA_W-1:0]   fifo_data;

    // Once the terminator is taken, no more words until the load is closed out.
    assign host.in_ready = (state == S_LOAD) && !term_pend;
    assign accept        = host.in_valid && host.in_ready;
    assign term_hit      = accept && hdr_exp && (host.in_data == TERM_WORD);
    assign bad_word      = accept && ((hdr_exp && !term_hit && !dim_ok(host.in_data[7:0])) ||
                                      ((wr_addr == '1) && !term_hit));
    assign write_ok      = accept && !bad_word;
    assign wt_ok         = wt_wr_en && (state == S_LOAD) && (state_d != S_ERR);

    assign issue         = (state == S_READ) && fifo_credit && (rd_addr < out_total);
    assign pop           = fifo_valid && host.res_ready;
    assign host.res_valid = fifo_valid;
    assign host.res_data  = fifo_data;
    assign host.res_last  = fifo_valid && (pop_idx == out_total - ONE);

    assign busy               = (state != S_LOAD);
    assign done               = (state == S_DONE);
    assign error              = (state == S_ERR);
    assign dut_run            = (state == S_KICK);
    assign osram_read_address = rd_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: load, kick, wait for busy edge pair, read back, finish.
    always_comb begin
        state_d = state;
        case (state)
            S_LOAD: begin
                if (bad_word) begin
                    state_d = S_ERR;
                end else if (term_pend) begin
                    state_d = (out_total == '0) ? S_DONE : S_KICK;
                end
            end
            S_KICK:    state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (dut_busy) begin
                    state_d = S_WAIT_LO;
                end else if (tmr == START_LIM) begin
                    state_d = S_ERR;
                end
            end
            S_WAIT_LO: begin
                if (!dut_busy) begin
                    state_d = S_READ;
                end else if (tmr == RUN_LIM) begin
                    state_d = S_ERR;
                end
            end
            S_READ: begin
                if (pop && host.res_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_LOAD;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // Per-state cycle timer, restarted on every state change.
    always_ff @(posedge clk) begin
        if (reset || (state != state_d)) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 16'd1;
        end
    end

    // Header/row parser and input SRAM write pointer.
    always_ff @(posedge clk) begin
        if (reset || (state == S_DONE)) begin
            wr_addr   <= '0;
            out_total <= '0;
            rows_left <= '0;
            hdr_exp   <= 1'b1;
            term_pend <= 1'b0;
        end else if (write_ok) begin
            wr_addr <= wr_addr + ONE;
            if (hdr_exp) begin
                if (term_hit) begin
                    term_pend <= 1'b1;
                end else begin
                    rows_left <= host.in_data[7:0];
                    out_total <= out_total + {{(ADDR_W-8){1'b0}}, host.in_data[7:0]} - TWO;
                    hdr_exp   <= 1'b0;
                end
            end else begin
                rows_left <= rows_left - 8'd1;
                if (rows_left == 8'd1) begin
                    hdr_exp <= 1'b1;
                end
            end
        end
    end

    // Registered input-SRAM and weight-SRAM write ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            isram_write_enable  <= 1'b0;
            isram_write_address <= '0;
            isram_write_data    <= '0;
            wmem_write_enable   <= 1'b0;
            wmem_write_address  <= '0;
            wmem_write_data     <= '0;
        end else begin
            isram_write_enable <= write_ok;
            if (write_ok) begin
                isram_write_address <= wr_addr;
                isram_write_data    <= host.in_data;
            end
            wmem_write_enable <= wt_ok;
            if (wt_ok) begin
                wmem_write_address <= ADDR_W'(WT_ADDR);
                wmem_write_data    <= {{(DATA_W-9){1'b0}}, wt_data};
            end
        end
    end

    // Readback address and popped-entry index, both restarting on entry to S_READ.
    always_ff @(posedge clk) begin
        if (reset || (state != S_READ)) begin
            rd_addr <= '0;
            pop_idx <= '0;
        end else begin
            if (issue) begin
                rd_addr <= rd_addr + ONE;
            end
            if (pop) begin
                pop_idx <= pop_idx + ONE;
            end
        end
    end

    bconv_rd_fifo #(.W(DATA_W)) u_rd_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != S_READ),
        .issue   (issue),
        .rd_data (osram_read_data),
        .pop     (pop),
        .credit  (fifo_credit),
        .valid   (fifo_valid),
        .data    (fifo_data)
    );

endmodule

// File: tb/tb_bconv_host_ctrl.sv
// tb/tb_bconv_host_ctrl.sv - directed self-checking bench for bconv_host_ctrl
module tb_bconv_host_ctrl;
    import bconv_host_ctrl_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        wt_wr_en;
    logic [8:0]  wt_data;
    logic        busy, done, error;
    logic [11:0] isram_write_address;
    logic [15:0] isram_write_data;
    logic        isram_write_enable;
    logic [11:0] wmem_write_address;
    logic [15:0] wmem_write_data;
    logic        wmem_write_enable;
    logic [11:0] osram_read_address;
    logic [15:0] osram_read_data;
    logic        dut_run;
    logic        dut_busy = 1'b0;

    bconv_host_ctrl_if #(.DATA_W(16)) hif ();

    bconv_host_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .host                (hif),
        .wt_wr_en            (wt_wr_en),
        .wt_data             (wt_data),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .isram_write_address (isram_write_address),
        .isram_write_data    (isram_write_data),
        .isram_write_enable  (isram_write_enable),
        .wmem_write_address  (wmem_write_address),
        .wmem_write_data     (wmem_write_data),
        .wmem_write_enable   (wmem_write_enable),
        .osram_read_address  (osram_read_address),
        .osram_read_data     (osram_read_data),
        .dut_run             (dut_run),
        .dut_busy            (dut_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] oval(input int i);
        return 16'hC300 ^ 16'(i * 37);
    endfunction

    // output SRAM model, 1-cycle read latency
    logic [15:0] osram [0:4095];
    always @(posedge clk) osram_read_data <= osram[osram_read_address];

    // accelerator model: mode 0 normal, 1 never busy, 2 busy stuck high
    int acc_mode = 0;
    int pend = 0;
    int hold = 0;
    always @(negedge clk) begin
        if (reset) begin
            dut_busy = 1'b0; pend = 0; hold = 0;
        end else if (dut_run) begin
            if (acc_mode != 1) pend = 2;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin dut_busy = 1'b1; hold = 6; end
        end else if (dut_busy && acc_mode == 0) begin
            hold--;
            if (hold == 0) dut_busy = 1'b0;
        end
    end

    // result consumer: always ready, or ready one cycle in three
    int rdy_mode = 0;
    int rdy_ph = 0;
    always @(posedge clk) begin
        #1;
        rdy_ph = (rdy_ph + 1) % 3;
        hif.res_ready = (rdy_mode == 0) || (rdy_ph == 0);
    end

    // event logs
    int          cyc = 0;
    int          run_cnt = 0, run_len = 0, run_max = 0;
    int          done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int          wm_cnt = 0;
    logic [15:0] wm_a, wm_d;
    logic [15:0] isr_a[$], isr_d[$], res_d[$], exp_isr[$];
    logic        res_l[$];
    logic        stall_prev = 1'b0;
    logic [15:0] stall_data;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            stall_prev = 1'b0;
            run_len = 0;
        end else begin
            if (isram_write_enable) begin
                isr_a.push_back({4'b0, isram_write_address});
                isr_d.push_back(isram_write_data);
            end
            if (wmem_write_enable) begin
                wm_cnt++; wm_a = {4'b0, wmem_write_address}; wm_d = wmem_write_data;
            end
            if (dut_run) begin
                run_len++;
                if (run_len == 1) run_cnt++;
                if (run_len > run_max) run_max = run_len;
            end else begin
                run_len = 0;
            end
            if (stall_prev) begin
                check("res_hold_valid", hif.res_valid, 1);
                check("res_hold_data", hif.res_data, stall_data);
            end
            stall_prev = hif.res_valid && !hif.res_ready;
            stall_data = hif.res_data;
            if (hif.res_valid && hif.res_ready) begin
                res_d.push_back(hif.res_data);
                res_l.push_back(hif.res_last);
                last_hs_cyc = cyc;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic clear_logs();
        isr_a.delete(); isr_d.delete(); res_d.delete(); res_l.delete(); exp_isr.delete();
        run_cnt = 0; run_max = 0; done_cnt = 0; wm_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic send(input logic [15:0] w);
        int n = 0;
        exp_isr.push_back(w);
        hif.in_valid = 1'b1;
        hif.in_data  = w;
        while (!hif.in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        hif.in_valid = 1'b0;
    endtask

    task automatic load_matrix(input int n, input logic [15:0] base);
        send(16'(n));
        for (int i = 0; i < n; i++) send(base + 16'(i));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        check(tag, done, 1);
    endtask

    task automatic wait_run(input int budget, input string tag);
        int n = 0;
        while (!dut_run && n < budget) begin @(negedge clk); n++; end
        check(tag, dut_run, 1);
    endtask

    task automatic check_isram(input string tag);
        check({tag, "_cnt"}, isr_a.size(), exp_isr.size());
        for (int i = 0; i < isr_a.size() && i < exp_isr.size(); i++) begin
            check({tag, "_addr"}, isr_a[i], i);
            check({tag, "_data"}, isr_d[i], exp_isr[i]);
        end
    endtask

    task automatic check_results(input string tag, input int n);
        check({tag, "_cnt"}, res_d.size(), n);
        for (int i = 0; i < res_d.size() && i < n; i++) begin
            check({tag, "_data"}, res_d[i], oval(i));
            check({tag, "_last"}, res_l[i], (i == n - 1));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        hif.in_valid = 1'b0;
        hif.in_data  = '0;
        wt_wr_en = 1'b0;
        wt_data  = '0;
        for (int i = 0; i < 4096; i++) osram[i] = oval(i);
        do_reset();

        // reset state
        check("rst_in_ready", hif.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_outs", {done, error, dut_run, hif.res_valid, isram_write_enable, wmem_write_enable}, 0);
        check("rst_waddr", isram_write_address, 0);

        // single 16x16 matrix with kernel write
        wt_wr_en = 1'b1; wt_data = 9'h1A5;
        @(negedge clk);
        wt_wr_en = 1'b0;
        load_matrix(16, 16'h1000);
        send(TERM_WORD);
        wait_done(400, "t1_done");
        repeat (3) @(negedge clk);
        check("t1_wm_cnt", wm_cnt, 1);
        check("t1_wm_addr", wm_a, 16'h0001);
        check("t1_wm_data", wm_d, 16'h01A5);
        check_isram("t1_isr");
        check("t1_runs", run_cnt, 1);
        check("t1_run_w", run_max, 1);
        check_results("t1_res", 14);
        check("t1_done_lat", done_cyc - last_hs_cyc, 1);
        check("t1_done_cnt", done_cnt, 1);

        // three matrices, consumer ready one cycle in three
        clear_logs();
        rdy_mode = 1;
        load_matrix(10, 16'h2000);
        load_matrix(12, 16'h3000);
        load_matrix(16, 16'h4000);
        send(TERM_WORD);
        wait_done(800, "t2_done");
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        check_isram("t2_isr");
        check("t2_runs", run_cnt, 1);
        check_results("t2_res", 32);
        check("t2_done_lat", done_cyc - last_hs_cyc, 1);

        // terminator-only loads
        clear_logs();
        send(TERM_WORD);
        wait_done(20, "t4_done_a");
        repeat (2) @(negedge clk);
        check_isram("t4_isr_a");
        clear_logs();
        send(TERM_WORD);
        wait_done(20, "t4_done_b");
        repeat (2) @(negedge clk);
        check_isram("t4_isr_b");
        check("t4_runs", run_cnt, 0);
        check("t4_res_cnt", res_d.size(), 0);
        check("t4_done_cnt", done_cnt, 1);

        // illegal header
        clear_logs();
        send(16'h000B);
        check("t5_err", error, 1);
        check("t5_in_ready", hif.in_ready, 0);
        send(TERM_WORD);
        repeat (20) @(negedge clk);
        check("t5_err_sticky", error, 1);
        check("t5_runs", run_cnt, 0);
        check("t5_isr_cnt", isr_a.size(), 0);

        // accelerator never goes busy
        do_reset();
        check("t6_err_clr", error, 0);
        acc_mode = 1;
        load_matrix(10, 16'h5000);
        send(TERM_WORD);
        wait_run(20, "t6_run");
        n = 0;
        while (!error && n < 40) begin @(negedge clk); n++; end
        check("t6_start_to", n, 17);

        // accelerator stuck busy
        do_reset();
        acc_mode = 2;
        load_matrix(12, 16'h6000);
        send(TERM_WORD);
        wait_run(20, "t7_run");
        n = 0;
        while (!error && n < 70000) begin @(negedge clk); n++; end
        check("t7_run_to", n, 65538);
        check("t7_runs", run_cnt, 1);

        do_reset();
        acc_mode = 0;
        check("end_err_clr", error, 0);
        check("end_run_low", dut_run, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bconv_host_ctrl.md
Name: bconv_host_ctrl

Overview:
- Host-side counterpart of the binary-convolution accelerator's control and SRAM interfaces.
- Loads input matrices from a valid/ready word stream into input SRAM and writes the 9-bit kernel into weight SRAM address 1.
- Raises dut_run and waits for dut_busy to rise and then fall.
- Reads the accelerator's result words back from output SRAM and streams them out with backpressure.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM/stream word width.
- WT_ADDR, 1, weight SRAM address holding the kernel.
- START_TO, 16, max cycles from dut_run to dut_busy rising.
- RUN_TO, 65535, max cycles dut_busy may stay high.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  load word valid
- in_ready  out  1  load word accepted when valid&ready
- in_data  in  16  load word (header, row, or terminator)
- wt_wr_en  in  1  kernel write strobe
- wt_data  in  9  kernel bits
- res_valid  out  1  result word valid
- res_ready  in  1  result consumer ready
- res_data  out  16  result word
- res_last  out  1  marks final result word
- busy  out  1  high in every state except S_LOAD
- done  out  1  one-cycle pulse after the last result handshake
- error  out  1  sticky fault flag
- isram_write_address  out  12  input SRAM write address
- isram_write_data  out  16  input SRAM write data
- isram_write_enable  out  1  input SRAM write strobe
- wmem_write_address  out  12  weight SRAM write address
- wmem_write_data  out  16  weight SRAM write data
- wmem_write_enable  out  1  weight SRAM write strobe
- osram_read_address  out  12  output SRAM read address
- osram_read_data  in  16  output SRAM data, 1-cycle read latency
- dut_run  out  1  accelerator start
- dut_busy  in  1  accelerator busy

Behaviour:
- Reset: state S_LOAD; all outputs 0 except in_ready=1; counters 0; error cleared only by reset.
- Input format: a header word whose low byte is N (10, 12 or 16), then N row words, repeated per matrix; the terminator is 16'h00FF.
- Every accepted word is written to input SRAM with a registered 1-cycle latency.
  - Write address starts at 0 and increments per word.
  - The terminator is also written.
- Parser, running in S_LOAD:
  - hdr_expected=1: N valid -> rows_left=N, out_total += N-2. Word==0x00FF -> end of load. Any other value -> error.
  - hdr_expected=0: decrement rows_left; re-expect a header when it reaches 0.
  - out_total is 12 bits.
- Address limit: accepting a word when the write address is 4095 and that word is not the terminator -> error.
- wt_wr_en: registered write of {7'd0,wt_data} to WT_ADDR, honoured in S_LOAD only; ignored in other states.
- States:
  - S_LOAD: in_ready=1.
    - On terminator: if out_total==0 go to S_DONE, else go to S_KICK the cycle after its SRAM write.
  - S_KICK: dut_run=1 for exactly one cycle, then S_WAIT_HI.
  - S_WAIT_HI: dut_busy=1 -> S_WAIT_LO. START_TO cycles elapse without it -> error.
  - S_WAIT_LO: dut_busy=0 -> S_READ with rd_addr=0. RUN_TO cycles elapse -> error.
  - S_READ:
    - Issue a read when (buffered + in-flight) < 2 and rd_addr < out_total; data is captured 1 cycle later into a 2-entry FIFO.
    - res_valid = FIFO non-empty; res_last = popping entry index == out_total-1.
    - The last handshake moves to S_DONE.
  - S_DONE: done=1 for one cycle; clear write address, out_total and parser; return to S_LOAD.
  - S_ERR: entered from any error; error=1, in_ready=0, no SRAM strobes, dut_run=0; exited only by reset.
- in_valid in any state other than S_LOAD is not accepted (in_ready=0).
- res_data/res_valid hold stable while res_valid & !res_ready.
- Reset mid-run: returns to S_LOAD immediately. dut_run is never left asserted. The accelerator is not otherwise signalled.

Decomposition:
- Shared package holds:
  - state enum;
  - DIM_10/12/16 constants;
  - TERM_WORD=16'h00FF;
  - WT_ADDR.
- One natural sub-module: bconv_rd_fifo, the 2-entry result buffer with credit count, also reusable for other SRAM readback paths.

Test Plan:
- Kernel 9'h1A5; load header 16, 16 rows, 0x00FF -> wmem[1]=0x01A5, isram addr 0..17 written; one dut_run pulse; 14 results at addr 0..13; res_last on the 14th; done 1 cycle later.
- Three matrices of N=10,12,16 + terminator -> out_total=8+10+14=32; exactly 32 reads, addresses 0..31 in order.
- res_ready toggling 1-of-3 cycles in S_READ -> no lost or duplicated word; data order matches output SRAM contents.
- Header 0x000B -> error=1 the next cycle; in_ready=0; no dut_run for the rest of the test.
- dut_busy held low after kick -> error after START_TO=16 cycles. Separately, dut_busy stuck high -> error after RUN_TO cycles.
- Terminator-only load -> no dut_run, no reads, done pulses; a subsequent load starts at isram address 0.
